serv_csr_seq: RTL

SERV_CSR_SEQ -- requirements
Module: serv_csr_seq

---
 rtl/serv_csr_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/serv_csr_seq.sv
// Control sequencer for bit-serial CSR access, trap/irq entry and mret.
// Optional timer-interrupt arbitration is enabled by defining SERV_CSR_SEQ_IRQ_EN.
module serv_csr_seq #(
    parameter int W = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_csr_req,
    input  logic [1:0] i_csr_sel,
    input  logic [1:0] i_csr_op,
    input  logic       i_trap_req,
    input  logic       i_mret_req,
    input  logic       i_irq,
    output logic       o_ack,
    output logic       o_done,
    output logic       o_busy,
    output logic       o_init,
    output logic       o_en,
    output logic       o_cnt0to3,
    output logic       o_cnt3,
    output logic       o_cnt7,
    output logic       o_cnt_done,
    output logic       o_trap,
    output logic       o_mret,
    output logic       o_mstatus_en,
    output logic       o_mie_en,
    output logic       o_mcause_en,
    output logic [1:0] o_csr_source
);

    // W is 1 or 4, so N is 32 or 8 and every step index fits in 5 bits.
    localparam int          N     = 32 / W;
    localparam logic [4:0]  LAST  = 5'(N - 1);
    localparam logic [4:0]  C03   = 5'(4 / W);
    localparam logic [4:0]  C3    = 5'(3 / W);
    localparam logic [4:0]  C7    = 5'(7 / W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        T_CSR  = 2'd0,
        T_TRAP = 2'd1,
        T_MRET = 2'd2
    } type_t;

    state_t     r_state;
    state_t     w_next;
    type_t      r_type;
    type_t      w_grant_type;
    logic [4:0] r_cnt;
    logic [1:0] r_sel;
    logic [1:0] r_op;
    logic       r_armed;
    logic       w_irq_win;
    logic       w_any_req;
    logic       w_grant;
    logic       w_last;
    logic       w_active;
    logic       w_csr_act;

`ifdef SERV_CSR_SEQ_IRQ_EN
    logic r_irq_blk;

    assign w_irq_win = i_irq & ~r_irq_blk;

    // One grant per irq assertion: blocked until the line is seen low while idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_irq_blk <= 1'b0;
        end else if (w_grant && w_irq_win) begin
            r_irq_blk <= 1'b1;
        end else if (r_state == S_IDLE && !i_irq) begin
            r_irq_blk <= 1'b0;
        end
    end
`else
    logic w_unused_irq;

    assign w_irq_win    = 1'b0;
    assign w_unused_irq = i_irq;
`endif

    assign w_any_req = w_irq_win | i_trap_req | i_mret_req | i_csr_req;
    // r_armed keeps a request held through reset from being granted before the first clock edge.
    assign w_grant   = r_armed && (r_state == S_IDLE) && w_any_req;
    assign w_last    = (r_cnt == LAST);
    assign w_active  = (r_state == S_INIT) || (r_state == S_RUN);

    always_comb begin
        w_grant_type = T_CSR;
        if (w_irq_win || i_trap_req) begin
            w_grant_type = T_TRAP;
        end else if (i_mret_req) begin
            w_grant_type = T_MRET;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_grant) w_next = (w_grant_type == T_CSR) ? S_INIT : S_RUN;
            S_INIT: if (w_last) w_next = S_RUN;
            S_RUN:  if (w_last) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_type  <= T_CSR;
            r_sel   <= 2'b00;
            r_op    <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
            if (w_active) begin
                r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
            end else begin
                r_cnt <= 5'd0;
            end
            if (w_grant) begin
                r_type <= w_grant_type;
                r_sel  <= i_csr_sel;
                r_op   <= i_csr_op;
            end
        end
    end

    assign w_csr_act    = w_active && (r_type == T_CSR);

    assign o_ack        = w_grant;
    assign o_done       = (r_state == S_DONE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_init       = (r_state == S_INIT);
    assign o_en         = (r_state == S_RUN);
    assign o_cnt0to3    = w_active && (r_cnt < C03);
    assign o_cnt3       = w_active && (r_cnt == C3);
    assign o_cnt7       = w_active && (r_cnt == C7);
    assign o_cnt_done   = w_active && w_last;
    assign o_trap       = (r_state == S_RUN) && (r_type == T_TRAP);
    assign o_mret       = (r_state == S_RUN) && (r_type == T_MRET) && w_last;
    assign o_mstatus_en = w_csr_act && (r_sel == 2'b01);
    assign o_mie_en     = w_csr_act && (r_sel == 2'b10);
    assign o_mcause_en  = w_csr_act && (r_sel == 2'b11);
    assign o_csr_source = ((r_state == S_RUN) && (r_type == T_CSR)) ? r_op : 2'b00;

endmodule
